// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: streams VLEN operand pairs through an external multiplier and accumulates the products.
// Result valid VLEN+2 cycles after start; in_ready only in RUN, DONE holds the result until out_ready.
module mac_seq_ctrl #(
    parameter int BITWIDTH = 32,
    parameter int VLEN     = 16,
    parameter int ACCW     = 2*BITWIDTH + $clog2(VLEN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BITWIDTH-1:0]   ain,
    input  logic [BITWIDTH-1:0]   bin,
    output logic [BITWIDTH-1:0]   mul_ain,
    output logic [BITWIDTH-1:0]   mul_bin,
    input  logic [2*BITWIDTH-1:0] mul_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACCW-1:0]       dout
);

    localparam int CNTW = $clog2(VLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNTW-1:0]       r_cnt;
    logic                  r_p_valid;
    logic [ACCW-1:0]       r_acc;
    logic [BITWIDTH-1:0]   r_ain;
    logic [BITWIDTH-1:0]   r_bin;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_start;

    assign w_start  = (r_state == S_IDLE) && start;
    assign w_accept = (r_state == S_RUN) && in_valid;
    assign w_last   = w_accept && (r_cnt == CNTW'(VLEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)                  w_next = S_RUN;
            S_RUN:   if (w_last)                 w_next = S_DRAIN;
            S_DRAIN:                             w_next = S_DONE;
            S_DONE:  if (out_ready)              w_next = S_IDLE;
            default:                             w_next = S_IDLE;
        endcase
    end

    // Product of the pair registered last edge is added this edge, so the
    // final product lands during DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_p_valid <= 1'b0;
            r_ain     <= '0;
            r_bin     <= '0;
        end else if (w_start) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_p_valid <= 1'b0;
        end else begin
            if (r_p_valid) begin
                r_acc <= r_acc + ACCW'(mul_dout);
            end
            r_p_valid <= w_accept;
            if (w_accept) begin
                r_ain <= ain;
                r_bin <= bin;
                r_cnt <= r_cnt + CNTW'(1);
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign in_ready  = (r_state == S_RUN);
    assign out_valid = (r_state == S_DONE);
    assign mul_ain   = r_ain;
    assign mul_bin   = r_bin;
    assign dout      = r_acc;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl (VLEN=4, BITWIDTH=8): directed runs, results checked by a queue-fed monitor.
module tb_mac_seq_ctrl;

    localparam int BW = 8;
    localparam int VL = 4;
    localparam int AW = 2*BW + $clog2(VL);

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            start     = 1'b0;
    logic            in_valid  = 1'b0;
    logic            out_ready = 1'b1;
    logic [BW-1:0]   ain       = '0;
    logic [BW-1:0]   bin       = '0;
    logic            busy;
    logic            in_ready;
    logic            out_valid;
    logic [BW-1:0]   mul_ain;
    logic [BW-1:0]   mul_bin;
    logic [2*BW-1:0] mul_dout;
    logic [AW-1:0]   dout;

    logic [AW-1:0]   exp_q[$];
    int              n_chk  = 0;
    int              n_pass = 0;

    mac_seq_ctrl #(.BITWIDTH(BW), .VLEN(VL), .ACCW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ain       (ain),
        .bin       (bin),
        .mul_ain   (mul_ain),
        .mul_bin   (mul_bin),
        .mul_dout  (mul_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
    );

    // External combinational multiplier
    assign mul_dout = (2*BW)'(mul_ain) * (2*BW)'(mul_bin);

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 64'(exp_q.size()), 64'd1);
            end else begin
                automatic logic [AW-1:0] e = exp_q.pop_front();
                chk("result_dout", 64'(dout), 64'(e));
            end
        end
    end

    // Pairs packed little-end first: pair i is av[8*i +: 8], bv[8*i +: 8].
    task automatic run_dot(input logic [31:0] av, input logic [31:0] bv,
                           input int gap_at, input int gap_len, input int start_at,
                           input logic [AW-1:0] exp_dout, input int exp_lat, input string tag);
        int lat;
        exp_q.push_back(exp_dout);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; lat = 1;
        for (int i = 0; i < VL; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1; lat++;
                end
            end
            in_valid = 1'b1;
            ain      = av[8*i +: 8];
            bin      = bv[8*i +: 8];
            start    = (i == start_at);
            @(posedge clk); #1; lat++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk({tag, "_drain_in_ready"}, 64'(in_ready), 64'd0);
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_done_in_ready"}, 64'(in_ready), 64'd0);
    endtask

    task automatic take_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
        chk({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_mul_ain", 64'(mul_ain), 64'd0);
        chk("reset_dout", 64'(dout), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1*2+3*4+5*6+7*8 = 100
        run_dot(32'h07050301, 32'h08060402, -1, 0, -1, 100, 6, "basic");
        take_result("basic");

        run_dot(32'h07050301, 32'h08060402, 2, 2, -1, 100, 8, "gap");
        take_result("gap");

        // 4 * 255*255 = 260100
        run_dot(32'hFFFFFFFF, 32'hFFFFFFFF, -1, 0, -1, 260100, 6, "max");
        take_result("max");

        out_ready = 1'b0;
        run_dot(32'h07050301, 32'h08060402, -1, 0, -1, 100, 6, "hold");
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("hold_out_valid", 64'(out_valid), 64'd1);
        chk("hold_dout", 64'(dout), 64'd100);
        chk("hold_busy", 64'(busy), 64'd1);
        take_result("hold");
        @(posedge clk); #1;
        chk("hold_stays_idle", 64'(busy), 64'd0);

        // in_valid while IDLE must not disturb operands or accumulator
        in_valid = 1'b1; ain = 8'd9; bin = 8'd9;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd0);
        chk("idle_mul_ain", 64'(mul_ain), 64'd7);
        chk("idle_mul_bin", 64'(mul_bin), 64'd8);
        chk("idle_dout", 64'(dout), 64'd100);
        chk("idle_busy", 64'(busy), 64'd0);
        in_valid = 1'b0;

        run_dot(32'h07050301, 32'h08060402, -1, 0, 2, 100, 6, "start_in_run");
        take_result("start_in_run");

        // Abort after two accepted pairs
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; in_valid = 1'b1; ain = 8'd3; bin = 8'd3;
        @(posedge clk); #1 ain = 8'd4;
        @(posedge clk); #1 in_valid = 1'b0; rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_mul_ain", 64'(mul_ain), 64'd0);
        chk("abort_mul_bin", 64'(mul_bin), 64'd0);
        chk("abort_dout", 64'(dout), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        run_dot(32'h01010101, 32'h01010101, -1, 0, -1, 4, 6, "post_reset");
        take_result("post_reset");

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
